// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32I core: datapath widths, decoded
// control bundle layout and ALU operation encoding.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  // Field order matches the packed ID_ctrl bus, MSB first.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
    logic    lui;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and front-end enables for the ID/EX boundary.
// Purely combinational; also reused by the stall-reporting path.
module hazard_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_branch_taken,
  input  logic              i_mem_busy,
  output logic              o_lu,
  output logic              o_load_use_stall,
  output logic              o_pc_write,
  output logic              o_if_id_write,
  output logic              o_if_id_flush
);

  logic w_rd_nonzero;
  logic w_rd_match;

  assign w_rd_nonzero = (i_ex_rd != '0);
  assign w_rd_match   = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);

  assign o_lu = i_ex_valid & i_ex_mem_read & w_rd_nonzero & i_id_valid & w_rd_match;

  // A taken branch discards the dependent instruction, so no stall is reported.
  assign o_load_use_stall = o_lu & ~i_branch_taken;

  assign o_pc_write    = ~i_mem_busy & (i_branch_taken | ~o_lu);
  assign o_if_id_write = ~i_mem_busy & ~o_load_use_stall;
  assign o_if_id_flush = i_branch_taken & ~i_mem_busy;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbles, WB->ID bypass and x0 sanitising.
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic [XLEN-1:0]   ID_pc,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic [XLEN-1:0]   ID_rs1_data,
  input  logic [XLEN-1:0]   ID_rs2_data,
  input  logic [XLEN-1:0]   ID_imm,
  input  logic [11:0]       ID_ctrl,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_rd,
  input  logic [XLEN-1:0]   WB_wdata,
  input  logic              EX_BranchTaken,
  input  logic              MEM_Busy,
  output logic              EX_valid,
  output logic [XLEN-1:0]   EX_pc,
  output logic [XLEN-1:0]   EX_rs1_data,
  output logic [XLEN-1:0]   EX_rs2_data,
  output logic [XLEN-1:0]   EX_imm,
  output logic [REG_AW-1:0] EX_rs1,
  output logic [REG_AW-1:0] EX_rs2,
  output logic [REG_AW-1:0] EX_rd,
  output logic [11:0]       EX_ctrl,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       Stall_Cnt,
  output logic [31:0]       Flush_Cnt,
`endif
  output logic              LoadUse_Stall
);

  import pipe_pkg::*;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_rs1_data;
  logic [XLEN-1:0]   r_ex_rs2_data;
  logic [XLEN-1:0]   r_ex_imm;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  ctrl_t             r_ex_ctrl;

  ctrl_t             w_id_ctrl;
  logic              w_rs1_bypass;
  logic              w_rs2_bypass;
  logic              w_lu;

  logic              w_nx_valid;
  logic [XLEN-1:0]   w_nx_pc;
  logic [XLEN-1:0]   w_nx_rs1_data;
  logic [XLEN-1:0]   w_nx_rs2_data;
  logic [XLEN-1:0]   w_nx_imm;
  logic [REG_AW-1:0] w_nx_rs1;
  logic [REG_AW-1:0] w_nx_rs2;
  logic [REG_AW-1:0] w_nx_rd;
  ctrl_t             w_nx_ctrl;

  assign w_id_ctrl = ctrl_t'(ID_ctrl);

  // The register file writes at the end of the cycle, so same-cycle WB data is newer.
  assign w_rs1_bypass = WB_RegWrite && (WB_rd != '0) && (WB_rd == ID_rs1);
  assign w_rs2_bypass = WB_RegWrite && (WB_rd != '0) && (WB_rd == ID_rs2);

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .i_ex_valid       (r_ex_valid),
    .i_ex_mem_read    (r_ex_ctrl.mem_read),
    .i_ex_rd          (r_ex_rd),
    .i_id_valid       (ID_valid),
    .i_id_rs1         (ID_rs1),
    .i_id_rs2         (ID_rs2),
    .i_branch_taken   (EX_BranchTaken),
    .i_mem_busy       (MEM_Busy),
    .o_lu             (w_lu),
    .o_load_use_stall (LoadUse_Stall),
    .o_pc_write       (PC_Write),
    .o_if_id_write    (IF_ID_Write),
    .o_if_id_flush    (IF_ID_Flush)
  );

  // Candidate load value: the decoded instruction, or a bubble when the slot is empty.
  always_comb begin
    w_nx_valid    = 1'b0;
    w_nx_pc       = '0;
    w_nx_rs1_data = '0;
    w_nx_rs2_data = '0;
    w_nx_imm      = '0;
    w_nx_rs1      = '0;
    w_nx_rs2      = '0;
    w_nx_rd       = '0;
    w_nx_ctrl     = CTRL_BUBBLE;
    if (ID_valid) begin
      w_nx_valid    = 1'b1;
      w_nx_pc       = ID_pc;
      w_nx_rs1_data = w_rs1_bypass ? WB_wdata : ID_rs1_data;
      w_nx_rs2_data = w_rs2_bypass ? WB_wdata : ID_rs2_data;
      w_nx_imm      = ID_imm;
      w_nx_rs1      = ID_rs1;
      w_nx_rs2      = ID_rs2;
      w_nx_rd       = ID_rd;
      w_nx_ctrl     = w_id_ctrl;
      // Forwarding does not check rd!=0, so writes to x0 are dropped here.
      w_nx_ctrl.reg_write = w_id_ctrl.reg_write & (ID_rd != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_ctrl     <= CTRL_BUBBLE;
    end else if (!MEM_Busy) begin
      if (EX_BranchTaken || w_lu) begin
        r_ex_valid    <= 1'b0;
        r_ex_pc       <= '0;
        r_ex_rs1_data <= '0;
        r_ex_rs2_data <= '0;
        r_ex_imm      <= '0;
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_rd       <= '0;
        r_ex_ctrl     <= CTRL_BUBBLE;
      end else begin
        r_ex_valid    <= w_nx_valid;
        r_ex_pc       <= w_nx_pc;
        r_ex_rs1_data <= w_nx_rs1_data;
        r_ex_rs2_data <= w_nx_rs2_data;
        r_ex_imm      <= w_nx_imm;
        r_ex_rs1      <= w_nx_rs1;
        r_ex_rs2      <= w_nx_rs2;
        r_ex_rd       <= w_nx_rd;
        r_ex_ctrl     <= w_nx_ctrl;
      end
    end
  end

  assign EX_valid    = r_ex_valid;
  assign EX_pc       = r_ex_pc;
  assign EX_rs1_data = r_ex_rs1_data;
  assign EX_rs2_data = r_ex_rs2_data;
  assign EX_imm      = r_ex_imm;
  assign EX_rs1      = r_ex_rs1;
  assign EX_rs2      = r_ex_rs2;
  assign EX_rd       = r_ex_rd;
  assign EX_ctrl     = r_ex_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (LoadUse_Stall && !MEM_Busy && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (IF_ID_Flush && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`endif

endmodule
